// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the instruction-memory loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    // Width of the frame word-count header (two bytes)
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        HDR_LO = 3'd0,
        HDR_HI = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : word_assembler
//  Description : Packs four LSB-first bytes into a 32-bit word and pulses
//                word_valid on the cycle after the fourth byte is taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data
);

    logic [1:0]        byte_cnt_q,   byte_cnt_d;
    logic [WORD_W-1:0] shift_q,      shift_d;
    logic              word_valid_q, word_valid_d;

    // Shift new bytes in at the top so the first byte ends up in bits [7:0]
    always_comb begin
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        word_valid_d = 1'b0;
        if (clear) begin
            byte_cnt_d = '0;
            shift_d    = '0;
        end else if (byte_valid) begin
            shift_d    = {byte_data, shift_q[WORD_W-1:BYTE_W]};
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
                word_valid_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            word_valid_q <= 1'b0;
        end else begin
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_valid = word_valid_q;
    assign word_data  = shift_q;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Receives a checksummed byte-stream image, writes it to IMEM
//                from word address 0 and releases the core once it checks out.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              rx_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_error
);

    loader_state_t     state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    // One extra bit so a full DEPTH-word image never wraps the index
    logic [ADDR_W:0]   word_idx_q,   word_idx_d;
    logic [BYTE_W-1:0] csum_q,       csum_d;
    logic [ADDR_W-1:0] addr_hold_q,  addr_hold_d;
    logic [WORD_W-1:0] wdata_hold_q, wdata_hold_d;

    logic              rx_hs;
    logic              asm_clear;
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic [CNT_W-1:0]  cnt_full;
    logic [CNT_W-1:0]  idx_ext;

    assign rx_ready = ~reset & (state_q inside {HDR_LO, HDR_HI, DATA, CSUM});
    assign rx_hs    = rx_valid & rx_ready;
    assign cnt_full = {rx_data, cnt_q[BYTE_W-1:0]};
    assign idx_ext  = CNT_W'(word_idx_q);

    word_assembler u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_valid (rx_hs & (state_q == DATA)),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    // A finished word is visible to IMEM for exactly the one strobe cycle;
    // afterwards the hold registers keep address and data stable.
    assign imem_we    = word_valid & ~reset;
    assign imem_addr  = imem_we ? word_idx_q[ADDR_W-1:0] : addr_hold_q;
    assign imem_wdata = imem_we ? word_data : wdata_hold_q;

    assign core_reset = reset | (state_q != DONE);
    assign load_done  = ~reset & (state_q == DONE);
    assign load_error = ~reset & (state_q == ERR);

    // Frame parser: header, payload word counting, checksum, reload
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        word_idx_d   = word_idx_q;
        csum_d       = csum_q;
        addr_hold_d  = addr_hold_q;
        wdata_hold_d = wdata_hold_q;
        asm_clear    = 1'b0;

        case (state_q)
            HDR_LO: begin
                if (rx_hs) begin
                    cnt_d   = {cnt_q[CNT_W-1:BYTE_W], rx_data};
                    csum_d  = csum_q ^ rx_data;
                    state_d = HDR_HI;
                end
            end
            HDR_HI: begin
                if (rx_hs) begin
                    cnt_d  = cnt_full;
                    csum_d = csum_q ^ rx_data;
                    if (cnt_full > CNT_W'(DEPTH)) begin
                        state_d = ERR;
                    end else if (cnt_full == '0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (rx_hs) begin
                    csum_d = csum_q ^ rx_data;
                end
                if (word_valid) begin
                    word_idx_d = word_idx_q + (ADDR_W+1)'(1);
                    if (idx_ext + CNT_W'(1) == cnt_q) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (rx_hs) begin
                    state_d = (rx_data == csum_q) ? DONE : ERR;
                end
            end
            DONE, ERR: begin
                if (reload) begin
                    state_d    = HDR_LO;
                    cnt_d      = '0;
                    word_idx_d = '0;
                    csum_d     = '0;
                    asm_clear  = 1'b1;
                end
            end
            default: state_d = HDR_LO;
        endcase

        if (imem_we) begin
            addr_hold_d  = word_idx_q[ADDR_W-1:0];
            wdata_hold_d = word_data;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HDR_LO;
            cnt_q        <= '0;
            word_idx_q   <= '0;
            csum_q       <= '0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_idx_q   <= word_idx_d;
            csum_q       <= csum_d;
            addr_hold_q  <= addr_hold_d;
            wdata_hold_q <= wdata_hold_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader with a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        reload = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        load_done;
    logic        load_error;

    imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    // status: 0 = loading, 1 = image accepted, 2 = image rejected
    int          m_status = 0;
    int          m_pos    = 0;
    int          m_cnt    = 0;
    int          k;
    logic [7:0]  m_xor    = 8'h00;
    logic        m_we     = 1'b0;
    logic [7:0]  m_addr   = 8'h00;
    logic [31:0] m_wdata  = 32'h0;
    logic [31:0] m_acc    = 32'h0;
    logic        m_hs;
    bit          m_init   = 1'b0;

    always @(posedge clk) begin
        m_hs = rx_valid && (m_status == 0) && !reset;
        m_we = 1'b0;
        if (reset) begin
            m_status = 0; m_pos = 0; m_cnt = 0; m_xor = 8'h00;
            m_addr = 8'h00; m_wdata = 32'h0; m_init = 1'b1;
        end else if (m_status != 0) begin
            if (reload) begin
                m_status = 0; m_pos = 0; m_cnt = 0; m_xor = 8'h00;
            end
        end else if (m_hs) begin
            if (m_pos == 0) begin
                m_cnt = int'(rx_data);
                m_xor = m_xor ^ rx_data;
            end else if (m_pos == 1) begin
                m_cnt = m_cnt + 256 * int'(rx_data);
                m_xor = m_xor ^ rx_data;
                if (m_cnt > 256) m_status = 2;
            end else if (m_pos == 2 + 4 * m_cnt) begin
                m_status = (rx_data == m_xor) ? 1 : 2;
            end else begin
                k = m_pos - 2;
                m_acc[8*(k%4) +: 8] = rx_data;
                m_xor = m_xor ^ rx_data;
                if (k % 4 == 3) begin
                    m_we    = 1'b1;
                    m_addr  = 8'(k / 4);
                    m_wdata = m_acc;
                end
            end
            m_pos++;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [31:0] mirror [0:255];
    int          n_writes = 0;

    always @(negedge clk) begin
        if (m_init) begin
            chk("rx_ready",   {31'b0, rx_ready},   {31'b0, (m_status == 0) && !reset});
            chk("imem_we",    {31'b0, imem_we},    {31'b0, m_we && !reset});
            chk("core_reset", {31'b0, core_reset}, {31'b0, reset || (m_status != 1)});
            chk("load_done",  {31'b0, load_done},  {31'b0, !reset && (m_status == 1)});
            chk("load_error", {31'b0, load_error}, {31'b0, !reset && (m_status == 2)});
            if (!reset) begin
                chk("imem_addr",  {24'b0, imem_addr}, {24'b0, m_addr});
                chk("imem_wdata", imem_wdata, m_wdata);
            end
            if (imem_we) begin
                mirror[imem_addr] = imem_wdata;
                n_writes++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] frm[$];
    bit         rnd_gap = 1'b0;

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        if (rnd_gap) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk); #1;
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
            end
        end
        @(negedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (!rx_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=rx_ready_low required=rx_ready_high byte=%h", b);
        end
        @(posedge clk);
    endtask

    // The checksum byte is sent after one idle cycle behind the last payload byte
    task automatic send_frame();
        for (int i = 0; i < frm.size(); i++) begin
            if (i == frm.size() - 1) idle(1);
            send_byte(frm[i]);
        end
        idle(2);
    endtask

    task automatic pulse_reload();
        @(negedge clk); #1; reload = 1'b1;
        @(negedge clk); #1; reload = 1'b0;
    endtask

    task automatic clear_mirror();
        for (int i = 0; i < 256; i++) mirror[i] = 32'h0;
    endtask

    int w0;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_mirror();
        repeat (3) @(negedge clk);
        chk("rst_rx_ready",   {31'b0, rx_ready},   32'd0);
        chk("rst_core_reset", {31'b0, core_reset}, 32'd1);
        chk("rst_imem_we",    {31'b0, imem_we},    32'd0);
        #1; reset = 1'b0;
        idle(1);

        // 1: two-word image with correct checksum
        frm = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h6F, 8'h00, 8'h20, 8'h00, 8'hFB};
        w0 = n_writes;
        send_frame();
        chk("s1_addr0", mirror[0], 32'h00A00513);
        chk("s1_addr1", mirror[1], 32'h0020006F);
        chk("s1_done",  {31'b0, load_done},  32'd1);
        chk("s1_crst",  {31'b0, core_reset}, 32'd0);
        chk("s1_writes", n_writes - w0, 32'd2);
        pulse_reload();

        // 2: same image, checksum off by one
        clear_mirror();
        frm[10] = 8'hFA;
        w0 = n_writes;
        send_frame();
        chk("s2_addr1",  mirror[1], 32'h0020006F);
        chk("s2_error",  {31'b0, load_error}, 32'd1);
        chk("s2_crst",   {31'b0, core_reset}, 32'd1);
        chk("s2_ready",  {31'b0, rx_ready},   32'd0);
        chk("s2_writes", n_writes - w0, 32'd2);
        pulse_reload();

        // 3: word count above DEPTH
        w0 = n_writes;
        send_byte(8'h01);
        send_byte(8'h01);
        idle(3);
        chk("s3_error",  {31'b0, load_error}, 32'd1);
        chk("s3_writes", n_writes - w0, 32'd0);
        pulse_reload();

        // 4: empty image
        frm = '{8'h00, 8'h00, 8'h00};
        w0 = n_writes;
        send_frame();
        chk("s4_done",   {31'b0, load_done}, 32'd1);
        chk("s4_writes", n_writes - w0, 32'd0);
        pulse_reload();

        // 5: image 1 with random valid gaps
        clear_mirror();
        frm = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h6F, 8'h00, 8'h20, 8'h00, 8'hFB};
        rnd_gap = 1'b1;
        w0 = n_writes;
        send_frame();
        rnd_gap = 1'b0;
        chk("s5_addr0",  mirror[0], 32'h00A00513);
        chk("s5_addr1",  mirror[1], 32'h0020006F);
        chk("s5_done",   {31'b0, load_done}, 32'd1);
        chk("s5_writes", n_writes - w0, 32'd2);
        pulse_reload();

        // 6: reset mid-frame, full reload, then a one-word overwrite
        clear_mirror();
        for (int i = 0; i < 7; i++) send_byte(frm[i]);
        idle(1);
        @(negedge clk); #1; reset = 1'b1;
        idle(2);
        @(negedge clk); #1; reset = 1'b0;
        w0 = n_writes;
        send_frame();
        chk("s6_done",   {31'b0, load_done}, 32'd1);
        chk("s6_writes", n_writes - w0, 32'd2);
        pulse_reload();
        chk("s6_reload_crst", {31'b0, core_reset}, 32'd1);
        chk("s6_reload_done", {31'b0, load_done},  32'd0);
        frm = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
        send_frame();
        chk("s6_addr0", mirror[0], 32'hDDCCBBAA);
        chk("s6_addr1", mirror[1], 32'h0020006F);
        chk("s6_done2", {31'b0, load_done}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
